dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory (`Data_Memory`: clk, rst, WE, A, WD, RD).
- **Port 0** is the pipeline MEM stage; **port 1** is the program loader / debug DMA.
- Grants one access per cycle, drives the memory's A/WE/WD, and returns registered read data or write acknowledgement one cycle later.
- Port 0 has fixed priority, bounded by an aging counter so port 1 cannot starve.
- Port 0 can lock the memory for read-modify-write sequences.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_age.sv | 28 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   localparam logic PORT_P0 = 1'b0;
   localparam logic PORT_P1 = 1'b1;

   localparam int AGE_W = 4;

endpackage

// File: rtl/dmem_arbiter_age.sv
// Saturating wait counter for port 1; sat marks the cycle the override may fire.
module dmem_arb_age
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic sat
);

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

   logic [AGE_W-1:0] age;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         age <= '0;
      end else if (!hold && (age < AGE_MAX)) begin
         age <= age + 1'b1;
      end
   end

   assign sat = (age == AGE_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory with port 1 aging and port 0 lock.
// state  | meaning
// OPEN   | normal priority arbitration, age override enabled
// LOCKED | port 0 owns the memory; port 1 is never granted
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p0_lock,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   lock_state_t       state, state_nxt;
   logic              gnt_any;
   logic              gnt_port;
   logic              gnt0, gnt1;
   logic              age_sat;
   logic              rsp0_q, rsp1_q;
   logic [DATA_W-1:0] rd0_q, rd1_q;

   dmem_arb_age #(.MAX_WAIT(MAX_WAIT)) u_age (
      .clk  (clk),
      .rst  (rst),
      .clr  (!p1_req_valid || gnt1),
      .hold (state == LOCKED),
      .sat  (age_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OPEN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OPEN:    if (gnt0 && p0_lock) state_nxt = LOCKED;
         LOCKED:  if ((gnt0 && !p0_lock) || (!p0_req_valid && !p0_lock)) state_nxt = OPEN;
         default: state_nxt = OPEN;
      endcase
   end

   always_comb begin
      gnt_any  = 1'b0;
      gnt_port = PORT_P0;
      if (!rst) begin
         if (state == LOCKED) begin
            gnt_any = p0_req_valid;
         end else if (age_sat && p1_req_valid) begin
            gnt_any  = 1'b1;
            gnt_port = PORT_P1;
         end else if (p0_req_valid) begin
            gnt_any = 1'b1;
         end else if (p1_req_valid) begin
            gnt_any  = 1'b1;
            gnt_port = PORT_P1;
         end
      end
   end

   assign gnt0         = gnt_any && (gnt_port == PORT_P0);
   assign gnt1         = gnt_any && (gnt_port == PORT_P1);
   assign p0_req_ready = gnt0;
   assign p1_req_ready = gnt1;

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (gnt0) begin
         mem_we = p0_we;
         mem_a  = p0_addr;
         mem_wd = p0_wdata;
      end else if (gnt1) begin
         mem_we = p1_we;
         mem_a  = p1_addr;
         mem_wd = p1_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_q <= 1'b0;
         rsp1_q <= 1'b0;
         rd0_q  <= '0;
         rd1_q  <= '0;
      end else begin
         rsp0_q <= gnt0;
         rsp1_q <= gnt1;
         if (gnt0) rd0_q <= p0_we ? '0 : mem_rd;
         if (gnt1) rd1_q <= p1_we ? '0 : mem_rd;
      end
   end

   // Masking by rst drops a response whose access was accepted just before reset.
   assign p0_rsp_valid = rsp0_q && !rst;
   assign p1_rsp_valid = rsp1_q && !rst;
   assign p0_rdata     = rst ? '0 : rd0_q;
   assign p1_rdata     = rst ? '0 : rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a behavioural arbiter model.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_req_valid, p0_req_ready, p0_we, p0_lock, p0_rsp_valid;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_rdata;
   logic          p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd, mem_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
      .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Data memory stand-in: combinational read, write at the clock edge.
   logic [DW-1:0] phys [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) phys[i] <= '0;
      end else if (mem_we) begin
         phys[mem_a[5:2]] <= mem_wd;
      end
   end
   assign mem_rd = phys[mem_a[5:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Behavioural model
   bit            m_locked = 0;
   int            m_age = 0;
   logic [DW-1:0] m_mem [16];
   bit            m_rv0 = 0, m_rv1 = 0;
   logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
   bit            acc0 = 0, acc1 = 0;

   always @(negedge clk) begin
      bit            e0, e1, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      if (rst) begin
         chk("rst_p0_ready", p0_req_ready, 0);
         chk("rst_p1_ready", p1_req_ready, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_p0_rsp", p0_rsp_valid, 0);
         chk("rst_p1_rsp", p1_rsp_valid, 0);
         chk("rst_p0_rdata", p0_rdata, 0);
         chk("rst_p1_rdata", p1_rdata, 0);
         m_locked = 0; m_age = 0;
         m_rv0 = 0; m_rv1 = 0; acc0 = 0; acc1 = 0;
         for (int i = 0; i < 16; i++) m_mem[i] = '0;
      end else begin
         e0 = 0; e1 = 0;
         if (m_locked)                        e0 = p0_req_valid;
         else if (m_age == MW && p1_req_valid) e1 = 1;
         else if (p0_req_valid)               e0 = 1;
         else if (p1_req_valid)               e1 = 1;
         ewe = 0; ea = '0; ewd = '0;
         if (e0) begin ewe = p0_we; ea = p0_addr; ewd = p0_wdata; end
         if (e1) begin ewe = p1_we; ea = p1_addr; ewd = p1_wdata; end
         chk("m_p0_ready", p0_req_ready, e0);
         chk("m_p1_ready", p1_req_ready, e1);
         chk("m_mem_we", mem_we, ewe);
         chk("m_mem_a", mem_a, ea);
         chk("m_mem_wd", mem_wd, ewd);
         chk("m_p0_rsp", p0_rsp_valid, m_rv0);
         chk("m_p1_rsp", p1_rsp_valid, m_rv1);
         if (m_rv0) chk("m_p0_rdata", p0_rdata, m_rd0);
         if (m_rv1) chk("m_p1_rdata", p1_rdata, m_rd1);
         m_rv0 = e0; m_rv1 = e1;
         if (e0) m_rd0 = p0_we ? '0 : m_mem[p0_addr[5:2]];
         if (e1) m_rd1 = p1_we ? '0 : m_mem[p1_addr[5:2]];
         if (ewe) m_mem[ea[5:2]] = ewd;
         if (!p1_req_valid || e1)           m_age = 0;
         else if (!m_locked && m_age < MW)  m_age++;
         if (!m_locked)
            m_locked = e0 && p0_lock;
         else if ((e0 && !p0_lock) || (!p0_req_valid && !p0_lock))
            m_locked = 0;
         acc0 = e0; acc1 = e1;
      end
   end

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_p0(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d, input bit lk);
      p0_req_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_lock = lk;
   endtask

   task automatic set_p1(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
      p1_req_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
   endtask

   initial begin
      rst = 1'b1;
      set_p0(0, 0, 0, 0, 0);
      set_p1(0, 0, 0, 0);
      nxt(); nxt();
      rst = 1'b0;

      // single port write then read
      set_p0(1, 1, 32'd4, 32'hAAAA5555, 0);
      smp();
      chk("sp_wr_ready", p0_req_ready, 1);
      chk("sp_mem_we", mem_we, 1);
      chk("sp_mem_a", mem_a, 32'd4);
      nxt();
      set_p0(1, 0, 32'd4, 0, 0);
      smp();
      chk("sp_ack_valid", p0_rsp_valid, 1);
      chk("sp_ack_rdata", p0_rdata, 0);
      nxt();
      set_p0(0, 0, 0, 0, 0);
      smp();
      chk("sp_rd_valid", p0_rsp_valid, 1);
      chk("sp_rd_data", p0_rdata, 32'hAAAA5555);
      nxt();

      // contention: four port 0 grants, then one port 1 grant
      set_p0(1, 0, 32'd0, 0, 0);
      set_p1(1, 1, 32'd8, 32'hDEADBEEF);
      for (int i = 0; i < 10; i++) begin
         smp();
         chk("cont_p0_gnt", p0_req_ready, (i % 5) != 4);
         chk("cont_p1_gnt", p1_req_ready, (i % 5) == 4);
         if (i == 4) begin
            chk("cont_p1_we", mem_we, 1);
            chk("cont_p1_a", mem_a, 32'd8);
            chk("cont_p1_wd", mem_wd, 32'hDEADBEEF);
         end
         nxt();
      end
      set_p0(0, 0, 0, 0, 0);
      set_p1(0, 0, 0, 0);
      smp(); nxt();

      // locked read-modify-write
      set_p0(1, 0, 32'd8, 0, 1);
      set_p1(1, 0, 32'd12, 0);
      smp();
      chk("lk_rd_p0_gnt", p0_req_ready, 1);
      chk("lk_rd_p1_gnt", p1_req_ready, 0);
      nxt();
      set_p0(0, 0, 0, 0, 1);
      smp();
      chk("lk_rd_rsp", p0_rsp_valid, 1);
      chk("lk_rd_data", p0_rdata, 32'hDEADBEEF);
      chk("lk_gap_p1_gnt", p1_req_ready, 0);
      nxt();
      set_p0(1, 1, 32'd8, 32'hDEADBEF0, 0);
      smp();
      chk("lk_wr_p0_gnt", p0_req_ready, 1);
      chk("lk_wr_p1_gnt", p1_req_ready, 0);
      nxt();
      set_p0(0, 0, 0, 0, 0);
      smp();
      chk("lk_rel_p1_gnt", p1_req_ready, 1);
      chk("lk_wr_ack", p0_rsp_valid, 1);
      nxt();
      set_p1(0, 0, 0, 0);
      smp(); nxt();

      // lock released by idle port 0
      set_p0(1, 0, 32'd0, 0, 1);
      smp();
      chk("ir_p0_gnt", p0_req_ready, 1);
      nxt();
      set_p0(0, 0, 0, 0, 0);
      set_p1(1, 0, 32'd4, 0);
      smp();
      chk("ir_p1_wait", p1_req_ready, 0);
      nxt();
      smp();
      chk("ir_p1_gnt", p1_req_ready, 1);
      nxt();
      set_p1(0, 0, 0, 0);
      smp(); nxt();

      // reset right after an accepted port 1 read
      set_p1(1, 0, 32'd4, 0);
      smp();
      chk("rm_p1_gnt", p1_req_ready, 1);
      nxt();
      set_p1(0, 0, 0, 0);
      set_p0(1, 1, 32'd0, 32'h12345678, 0);
      rst = 1'b1;
      smp();
      chk("rm_p1_rsp", p1_rsp_valid, 0);
      chk("rm_p1_rdata", p1_rdata, 0);
      chk("rm_mem_we", mem_we, 0);
      chk("rm_p0_ready", p0_req_ready, 0);
      nxt();
      rst = 1'b0;
      set_p0(0, 0, 0, 0, 0);
      smp(); nxt();

      // idle
      for (int i = 0; i < 10; i++) begin
         smp();
         chk("idle_mem_we", mem_we, 0);
         chk("idle_mem_a", mem_a, 0);
         chk("idle_p0_rsp", p0_rsp_valid, 0);
         chk("idle_p1_rsp", p1_rsp_valid, 0);
         nxt();
      end

      // randomized traffic; request fields held until accepted
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!p0_req_valid || acc0) begin
            p0_req_valid = ($urandom_range(0, 2) != 0);
            p0_we        = 1'($urandom_range(0, 1));
            p0_addr      = 32'($urandom_range(0, 15)) << 2;
            p0_wdata     = $urandom;
            p0_lock      = ($urandom_range(0, 3) == 0);
         end
         if (!p1_req_valid || acc1) begin
            p1_req_valid = ($urandom_range(0, 1) != 0);
            p1_we        = 1'($urandom_range(0, 1));
            p1_addr      = 32'($urandom_range(0, 15)) << 2;
            p1_wdata     = $urandom;
         end
         nxt();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
